// File: rtl/leaf_tx_queue.sv
// leaf_tx_queue: PE-side transmitter for a leaf's bus interface.
// Queues {dest, payload} requests from the PE in a small FIFO and presents
// the head packet {valid, dest, payload} on pkt_o. The packet is held until
// the interface reports a cycle without resend, so a packet is never lost
// when the bus slot is occupied by a passing packet.
// Optional build macro LEAF_TX_STATS_EN adds sent_count/retry_count outputs.
module leaf_tx_queue #(
    parameter int num_leaves   = 2,
    parameter int payload_sz   = 1,
    parameter logic [$clog2(num_leaves)-1:0] addr = '0,
    parameter int fifo_depth   = 4,
    parameter int starve_limit = 16,
    parameter int p_sz         = 1 + $clog2(num_leaves) + payload_sz
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(num_leaves)-1:0] in_dest,
    input  logic [payload_sz-1:0]         in_payload,
    output logic [p_sz-1:0]               pkt_o,
    input  logic                          resend_i,
    output logic                          busy,
    output logic                          starve,
    output logic                          self_send
`ifdef LEAF_TX_STATS_EN
    ,
    output logic [15:0]                   sent_count,
    output logic [15:0]                   retry_count
`endif
);

    localparam int aw = $clog2(num_leaves);
    localparam int ew = aw + payload_sz;
    localparam int pw = $clog2(fifo_depth);
    localparam int cw = pw + 1;
    localparam int sw = $clog2(starve_limit + 1);

    localparam logic [cw-1:0] full_count = cw'(fifo_depth);
    localparam logic [sw-1:0] starve_max = sw'(starve_limit);

    localparam logic IDLE    = 1'b0;
    localparam logic PRESENT = 1'b1;

    logic [ew-1:0] mem [fifo_depth];
    logic [pw-1:0] wr_ptr;
    logic [pw-1:0] rd_ptr;
    logic [cw-1:0] count;
    logic          state;
    logic [sw-1:0] reject_cnt;

    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          taken;
    logic          rejected;
    logic [ew-1:0] head;

    assign fifo_empty = (count == '0);
    assign in_ready   = (count != full_count);
    assign push       = in_valid && in_ready;
    assign taken      = (state == PRESENT) && !resend_i;
    assign rejected   = (state == PRESENT) && resend_i;
    assign head       = mem[rd_ptr];
    // The FIFO head moves into staging whenever staging is free or being
    // vacated this cycle. count is registered, so a same-cycle push is only
    // seen on the following cycle.
    assign pop        = ((state == IDLE) || !resend_i) && !fifo_empty;
    assign busy       = !fifo_empty || (state == PRESENT);

    // FIFO storage; contents need no reset because pointers and count guard them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_dest, in_payload};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Two-state presenter: the staging register is pkt_o itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pkt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pkt_o <= {1'b1, head};
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (!resend_i) begin
                        if (!fifo_empty) begin
                            pkt_o <= {1'b1, head};
                        end else begin
                            pkt_o <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    pkt_o <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Consecutive-reject counter and starve flag; starve tracks the saturated count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reject_cnt <= '0;
            starve     <= 1'b0;
        end else if (rejected) begin
            if (reject_cnt != starve_max) begin
                reject_cnt <= reject_cnt + 1'b1;
                starve     <= ((reject_cnt + 1'b1) == starve_max);
            end else begin
                starve     <= 1'b1;
            end
        end else begin
            reject_cnt <= '0;
            starve     <= 1'b0;
        end
    end

    // One-cycle pulse when an accepted request targets this leaf; the packet still goes out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            self_send <= 1'b0;
        end else begin
            self_send <= push && (in_dest == addr);
        end
    end

`ifdef LEAF_TX_STATS_EN
    // Saturating counters of delivered packets and rejected presentation cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sent_count  <= '0;
            retry_count <= '0;
        end else begin
            if (taken && (sent_count != 16'hFFFF)) begin
                sent_count <= sent_count + 16'd1;
            end
            if (rejected && (retry_count != 16'hFFFF)) begin
                retry_count <= retry_count + 16'd1;
            end
        end
    end
`else
    logic unused_taken;
    assign unused_taken = taken;
`endif

endmodule

// File: tb/tb_leaf_tx_queue.sv
// tb_leaf_tx_queue: directed self-checking bench for leaf_tx_queue.
// Configuration: num_leaves=4, payload_sz=8, addr=1, fifo_depth=4, starve_limit=3.
// Build with LEAF_TX_STATS_EN defined to also check the statistics counters.
module tb_leaf_tx_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_dest;
    logic [7:0]  in_payload;
    logic [10:0] pkt_o;
    logic        resend_i;
    logic        busy;
    logic        starve;
    logic        self_send;
`ifdef LEAF_TX_STATS_EN
    logic [15:0] sent_count;
    logic [15:0] retry_count;
`endif

    int tests_run;
    int tests_failed;

    leaf_tx_queue #(
        .num_leaves  (4),
        .payload_sz  (8),
        .addr        (2'd1),
        .fifo_depth  (4),
        .starve_limit(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dest    (in_dest),
        .in_payload (in_payload),
        .pkt_o      (pkt_o),
        .resend_i   (resend_i),
        .busy       (busy),
        .starve     (starve),
        .self_send  (self_send)
`ifdef LEAF_TX_STATS_EN
        ,
        .sent_count (sent_count),
        .retry_count(retry_count)
`endif
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, settle 1 ns after it.
    task automatic applyStimulus(input logic v, input logic [1:0] d, input logic [7:0] p, input logic r);
        in_valid   = v;
        in_dest    = d;
        in_payload = p;
        resend_i   = r;
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges and return just after the next edge.
    task automatic doReset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_dest      = 2'd0;
        in_payload   = 8'h00;
        resend_i     = 1'b0;

        #12;
        checkOutput("reset_pkt",       pkt_o,     0);
        checkOutput("reset_in_ready",  in_ready,  1);
        checkOutput("reset_busy",      busy,      0);
        checkOutput("reset_starve",    starve,    0);
        checkOutput("reset_self_send", self_send, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);

        // Single send: valid two edges after the request, for one cycle.
        applyStimulus(1'b1, 2'd2, 8'hA5, 1'b0);
        checkOutput("single_pkt0",  pkt_o, 0);
        checkOutput("single_busy0", busy,  1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("single_pkt1",  pkt_o, 11'h6A5);
        checkOutput("single_busy1", busy,  1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("single_pkt2",  pkt_o, 0);
        checkOutput("single_busy2", busy,  0);

        // Retry: four rejected cycles then accept.
        doReset();
        applyStimulus(1'b1, 2'd3, 8'h0F, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        checkOutput("retry_pkt_first", pkt_o,  11'h70F);
        checkOutput("retry_starve0",   starve, 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
            checkOutput($sformatf("retry_pkt_hold%0d", i), pkt_o, 11'h70F);
            checkOutput($sformatf("retry_starve%0d", i), starve, (i >= 3) ? 1 : 0);
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("retry_pkt_done",    pkt_o,  0);
        checkOutput("retry_starve_done", starve, 0);
`ifdef LEAF_TX_STATS_EN
        checkOutput("retry_count", retry_count, 4);
        checkOutput("sent_count",  sent_count,  1);
`endif

        // Back-to-back: four pushes on consecutive edges, one packet per cycle out.
        applyStimulus(1'b1, 2'd0, 8'h01, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'h02, 1'b0);
        checkOutput("b2b_pkt1", pkt_o, 11'h401);
        applyStimulus(1'b1, 2'd0, 8'h03, 1'b0);
        checkOutput("b2b_pkt2", pkt_o, 11'h402);
        applyStimulus(1'b1, 2'd0, 8'h04, 1'b0);
        checkOutput("b2b_pkt3", pkt_o, 11'h403);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("b2b_pkt4", pkt_o, 11'h404);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("b2b_idle", pkt_o, 0);

        // Full: five pushes under resend; FIFO holds four, staging one.
        applyStimulus(1'b1, 2'd2, 8'h11, 1'b1);
        applyStimulus(1'b1, 2'd2, 8'h12, 1'b1);
        checkOutput("full_pkt_head", pkt_o, 11'h611);
        applyStimulus(1'b1, 2'd2, 8'h13, 1'b1);
        applyStimulus(1'b1, 2'd2, 8'h14, 1'b1);
        checkOutput("full_ready_3", in_ready, 1);
        applyStimulus(1'b1, 2'd2, 8'h15, 1'b1);
        checkOutput("full_ready_4", in_ready, 0);
        checkOutput("full_pkt_held", pkt_o, 11'h611);
        // Offer a sixth request while full; it must be ignored.
        applyStimulus(1'b1, 2'd2, 8'h16, 1'b0);
        checkOutput("full_pkt2", pkt_o, 11'h612);
        for (int i = 3; i <= 5; i++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
            checkOutput($sformatf("full_pkt%0d", i), pkt_o, 11'h610 + i);
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("full_idle", pkt_o, 0);
        checkOutput("full_busy", busy,  0);

        // Self-send: pulse for one cycle, packet still delivered.
        applyStimulus(1'b1, 2'd1, 8'h3C, 1'b0);
        checkOutput("self_pulse", self_send, 1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("self_pulse_end", self_send, 0);
        checkOutput("self_pkt",       pkt_o,     11'h53C);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("self_idle", pkt_o, 0);

        // Asynchronous reset with packets queued and staged.
        applyStimulus(1'b1, 2'd3, 8'h21, 1'b1);
        applyStimulus(1'b1, 2'd3, 8'h22, 1'b1);
        applyStimulus(1'b1, 2'd3, 8'h23, 1'b1);
        applyStimulus(1'b1, 2'd3, 8'h24, 1'b1);
        checkOutput("pre_reset_busy", busy,  1);
        checkOutput("pre_reset_pkt",  pkt_o, 11'h721);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_pkt",   pkt_o,    0);
        checkOutput("async_reset_busy",  busy,     0);
        checkOutput("async_reset_ready", in_ready, 1);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
            checkOutput($sformatf("post_reset_pkt%0d", i), pkt_o, 0);
            checkOutput($sformatf("post_reset_busy%0d", i), busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
